// File: rtl/rq_coef_mac_pkg.sv
// Shared constants for the Rq coefficient MAC: widths,
// ternary operand codes and the sequencer state encoding.
package rq_pkg;

  localparam int Q_BITS = 13;
  localparam int N_HRSS = 701;

  localparam logic [1:0] TERN_ZERO = 2'b00;
  localparam logic [1:0] TERN_POS  = 2'b01;
  localparam logic [1:0] TERN_NEG  = 2'b11;
  localparam logic [1:0] TERN_RSV  = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_ACC,
    S_HOLD
  } state_e;

endpackage

// File: rtl/rq_coef_mac_if.sv
// Result handshake between the coefficient MAC and
// the downstream coefficient writer.
interface rq_coef_mac_if #(
  parameter int Q_BITS = 13
);

  logic              out_valid;
  logic              out_ready;
  logic [Q_BITS-1:0] out_coef;

  modport master (
    output out_valid,
    output out_coef,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_coef,
    output out_ready
  );

endinterface

// File: rtl/rq_coef_mac_csa.sv
// Carry-select adder: 4-bit ripple low block, upper
// blocks precomputed for both carry-in values.
module carryselectadder #(
  parameter int W = 13
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic         cin_i,
  output logic [W-1:0] sum_o
);

  localparam int HW = W - 8;

  logic [4:0]    lo;
  logic [4:0]    m0;
  logic [4:0]    m1;
  logic [HW-1:0] h0;
  logic [HW-1:0] h1;
  logic          c4;
  logic          c8;

  assign lo = {1'b0, a_i[3:0]} + {1'b0, b_i[3:0]}
            + {4'd0, cin_i};
  assign m0 = {1'b0, a_i[7:4]} + {1'b0, b_i[7:4]};
  assign m1 = m0 + 5'd1;
  assign h0 = a_i[W-1:8] + b_i[W-1:8];
  assign h1 = h0 + HW'(1);

  assign c4 = lo[4];
  assign c8 = c4 ? m1[4] : m0[4];

  // Top carry is dropped: that is the mod 2^W wrap.
  assign sum_o = {c8 ? h1 : h0,
                  c4 ? m1[3:0] : m0[3:0],
                  lo[3:0]};

endmodule

// File: rtl/rq_coef_mac.sv
// One coefficient of a*b in Z_2^Q[x]/(x^N-1), b ternary.
// RQ_MAC_RESERVED_CHK_EN: flag reserved b codes on err.
module rq_coef_mac
  import rq_pkg::*;
#(
  parameter int N      = N_HRSS,
  parameter int Q_BITS = rq_pkg::Q_BITS,
  localparam int IW    = $clog2(N)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [IW-1:0]     k,
  output logic              busy,
  output logic [IW-1:0]     a_addr,
  input  logic [Q_BITS-1:0] a_rdata,
  output logic [IW-1:0]     b_addr,
  input  logic [1:0]        b_rdata,
  output logic              err,
  rq_coef_mac_if.master     out_if
);

  state_e            state_q;
  logic [IW-1:0]     a_addr_q;
  logic [IW-1:0]     b_addr_q;
  logic [IW-1:0]     cnt_q;
  logic [Q_BITS-1:0] acc_q;
  logic [Q_BITS-1:0] acc_d;
  logic [Q_BITS-1:0] coef_q;
  logic [Q_BITS-1:0] in2;
  logic              cin;
  logic              busy_q;
  logic              valid_q;
  logic              accept;
  logic              last_addr;
  logic [IW-1:0]     a_dec;

  assign accept    = (state_q == S_IDLE) && start
                   && (int'(k) < N);
  assign last_addr = (b_addr_q == IW'(N - 1));
  assign a_dec     = (a_addr_q == '0) ? IW'(N - 1)
                                      : a_addr_q - IW'(1);

  always_comb begin
    in2 = '0;
    cin = 1'b0;
    unique case (1'b1)
      (b_rdata == TERN_POS): in2 = a_rdata;
      (b_rdata == TERN_NEG): begin
        in2 = ~a_rdata;
        cin = 1'b1;
      end
      default: ;
    endcase
  end

  carryselectadder #(
    .W (Q_BITS)
  ) u_add (
    .a_i   (acc_q),
    .b_i   (in2),
    .cin_i (cin),
    .sum_o (acc_d)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      a_addr_q <= '0;
      b_addr_q <= '0;
      cnt_q    <= '0;
      acc_q    <= '0;
      coef_q   <= '0;
      busy_q   <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (accept) begin
            state_q  <= S_ISSUE;
            busy_q   <= 1'b1;
            acc_q    <= '0;
            cnt_q    <= '0;
            a_addr_q <= k;
            b_addr_q <= '0;
          end
        end
        S_ISSUE: begin
          state_q <= S_ACC;
          if (!last_addr) begin
            a_addr_q <= a_dec;
            b_addr_q <= b_addr_q + IW'(1);
          end
        end
        S_ACC: begin
          acc_q <= acc_d;
          cnt_q <= cnt_q + IW'(1);
          if (!last_addr) begin
            a_addr_q <= a_dec;
            b_addr_q <= b_addr_q + IW'(1);
          end
          // cnt_q indexes the term being consumed now
          if (cnt_q == IW'(N - 1)) begin
            state_q <= S_HOLD;
            valid_q <= 1'b1;
            coef_q  <= acc_d;
          end
        end
        S_HOLD: begin
          if (out_if.out_ready) begin
            state_q <= S_IDLE;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

`ifdef RQ_MAC_RESERVED_CHK_EN
  logic err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if (accept) begin
      err_q <= 1'b0;
    end else if (state_q == S_ACC
                 && b_rdata == TERN_RSV) begin
      err_q <= 1'b1;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  assign busy             = busy_q;
  assign a_addr           = a_addr_q;
  assign b_addr           = b_addr_q;
  assign out_if.out_valid = valid_q;
  assign out_if.out_coef  = coef_q;

endmodule

// File: tb/tb_rq_coef_mac.sv
// Directed and random checks of rq_coef_mac (N=4)
// against a polynomial-product reference model.
module tb_rq_coef_mac;

  localparam int N  = 4;
  localparam int IW = 2;
  localparam int QB = 13;

`ifdef RQ_MAC_RESERVED_CHK_EN
  localparam bit CHK_EN = 1'b1;
`else
  localparam bit CHK_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [IW-1:0] k = '0;
  logic          busy;
  logic [IW-1:0] a_addr;
  logic [IW-1:0] b_addr;
  logic [QB-1:0] a_rdata;
  logic [1:0]    b_rdata;
  logic          err;

  int          a_mem [N];
  logic [1:0]  b_mem [N];
  int          total = 0;
  int          passed = 0;

  always #5 clk = ~clk;

  rq_coef_mac_if #(.Q_BITS(QB)) oif ();

  rq_coef_mac #(
    .N      (N),
    .Q_BITS (QB)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .k       (k),
    .busy    (busy),
    .a_addr  (a_addr),
    .a_rdata (a_rdata),
    .b_addr  (b_addr),
    .b_rdata (b_rdata),
    .err     (err),
    .out_if  (oif.master)
  );

  always @(posedge clk) begin
    a_rdata <= QB'(a_mem[a_addr]);
    b_rdata <= b_mem[b_addr];
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0d expected=%0d",
                tag, obs, exp);
  endtask

  // c_k = sum_j b_j * a_{(k-j) mod N}, reduced mod 2^13
  function automatic int ref_c(input int kk);
    int s;
    s = 0;
    for (int j = 0; j < N; j++) begin
      int ai;
      ai = (kk - j + N) % N;
      if (b_mem[j] == 2'b01) s += a_mem[ai];
      if (b_mem[j] == 2'b11) s -= a_mem[ai];
    end
    return s & ((1 << QB) - 1);
  endfunction

  function automatic bit ref_err();
    bit e;
    e = 1'b0;
    for (int j = 0; j < N; j++)
      if (b_mem[j] == 2'b10) e = 1'b1;
    return e & CHK_EN;
  endfunction

  task automatic setm(input int a0, a1, a2, a3,
                      input logic [1:0] b0, b1, b2, b3);
    a_mem[0] = a0; a_mem[1] = a1;
    a_mem[2] = a2; a_mem[3] = a3;
    b_mem[0] = b0; b_mem[1] = b1;
    b_mem[2] = b2; b_mem[3] = b3;
  endtask

  task automatic compute(input string tag, input int kk,
                         input int exp_c, input bit exp_e,
                         input int rdly, input bit poke);
    int cyc;
    bit seen;
    oif.out_ready = (rdly == 0);
    start = 1'b1;
    k = IW'(kk);
    @(negedge clk);
    cyc = 1;
    start = 1'b0;
    chk({tag, "_busy"}, 32'(busy), 1);
    seen = oif.out_valid;
    while (!seen && cyc < 4 * N + 20) begin
      start = poke && (cyc == 3);
      k = IW'(kk + 1);
      @(negedge clk);
      cyc++;
      seen = oif.out_valid;
    end
    start = 1'b0;
    chk({tag, "_valid"}, 32'(oif.out_valid), 1);
    if (rdly == 0)
      chk({tag, "_lat"}, cyc, N + 2);
    chk({tag, "_coef"}, 32'(oif.out_coef), exp_c);
    chk({tag, "_err"}, 32'(err), 32'(exp_e));
    for (int i = 0; i < rdly; i++) begin
      start = poke && (i == 0);
      @(negedge clk);
      chk({tag, "_hold_coef"}, 32'(oif.out_coef), exp_c);
      chk({tag, "_hold_busy"}, 32'(busy), 1);
    end
    start = 1'b0;
    oif.out_ready = 1'b1;
    @(negedge clk);
    chk({tag, "_done_busy"}, 32'(busy), 0);
    chk({tag, "_done_valid"}, 32'(oif.out_valid), 0);
  endtask

  task automatic addr_seq();
    int exp_a [N];
    int cyc;
    exp_a[0] = 0; exp_a[1] = 3;
    exp_a[2] = 2; exp_a[3] = 1;
    oif.out_ready = 1'b1;
    start = 1'b1;
    k = '0;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < N; i++) begin
      chk($sformatf("aaddr%0d", i), 32'(a_addr), exp_a[i]);
      chk($sformatf("baddr%0d", i), 32'(b_addr), i);
      @(negedge clk);
    end
    cyc = N + 1;
    while (!oif.out_valid && cyc < 4 * N + 20) begin
      @(negedge clk);
      cyc++;
    end
    chk("aseq_coef", 32'(oif.out_coef), 4);
    @(negedge clk);
  endtask

  initial begin
    oif.out_ready = 1'b0;
    setm(1, 2, 3, 4, 2'b01, 2'b00, 2'b00, 2'b00);
    @(negedge clk);
    @(negedge clk);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_valid", 32'(oif.out_valid), 0);
    chk("rst_coef", 32'(oif.out_coef), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_aaddr", 32'(a_addr), 0);
    chk("rst_baddr", 32'(b_addr), 0);
    rst = 1'b0;

    compute("pos", 2, 3, 1'b0, 0, 1'b0);

    setm(1, 2, 3, 4, 2'b11, 2'b00, 2'b00, 2'b00);
    compute("neg", 0, 8191, 1'b0, 0, 1'b0);

    setm(8191, 8191, 8191, 8191,
         2'b01, 2'b01, 2'b01, 2'b01);
    compute("wrap", 3, 8188, 1'b0, 0, 1'b0);

    setm(1, 2, 3, 4, 2'b00, 2'b01, 2'b00, 2'b00);
    compute("idx", 0, 4, 1'b0, 0, 1'b0);
    addr_seq();

    setm(1, 2, 3, 4, 2'b01, 2'b11, 2'b01, 2'b00);
    compute("bp", 1, ref_c(1), 1'b0, 5, 1'b1);
    compute("after_bp", 3, ref_c(3), 1'b0, 0, 1'b0);

    setm(1, 2, 3, 4, 2'b01, 2'b00, 2'b00, 2'b00);
    oif.out_ready = 1'b1;
    start = 1'b1;
    k = 2'd0;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_busy", 32'(busy), 0);
    chk("midrst_valid", 32'(oif.out_valid), 0);
    for (int i = 0; i < N + 4; i++) begin
      @(negedge clk);
      chk("midrst_novalid", 32'(oif.out_valid), 0);
    end
    compute("postrst", 1, 2, 1'b0, 0, 1'b0);

    setm(1, 2, 3, 4, 2'b10, 2'b01, 2'b00, 2'b00);
    compute("rsv", 1, 1, CHK_EN, 2, 1'b0);
    chk("rsv_keep", 32'(err), 32'(CHK_EN));
    setm(1, 2, 3, 4, 2'b01, 2'b00, 2'b00, 2'b00);
    compute("rsv_clr", 1, 2, 1'b0, 0, 1'b0);

    for (int t = 0; t < 24; t++) begin
      int kk;
      int rd;
      for (int j = 0; j < N; j++) begin
        a_mem[j] = int'($urandom_range(0, 8191));
        b_mem[j] = 2'($urandom_range(0, 3));
      end
      kk = int'($urandom_range(0, N - 1));
      rd = int'($urandom_range(0, 3));
      compute($sformatf("rnd%0d", t), kk, ref_c(kk),
              ref_err(), rd, rd[0]);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
